dram_bram_responder: RTL and testbench

- Responder end of the core-side DRAM request interface: addr_dram / din_dram / rw_dram / valid_dram in, dout_dram / ready_dram out.
- Serves requests from an on-chip BRAM array with programmable latency.
- Stands in for the DDR2 controller top, so the core and its benches run without the memory model or the memory clock.
- Single clock domain (sys clock); no clock crossing.

---
 rtl/dram_bram_responder.sv | 122 ++++++++++++
 tb/tb_dram_bram_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dram_bram_responder.sv
// BRAM-backed responder for the core-side DRAM request port, with programmable latency.
// Define DRAM_RESP_RANDLAT_EN to add 0..7 pseudo-random extra cycles per request.
module dram_bram_responder #(
   parameter int ADDR_W     = 27,
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 14,
   parameter int LATENCY    = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] addr_dram,
   input  logic [DATA_W-1:0] din_dram,
   input  logic              rw_dram,
   input  logic              valid_dram,
   output logic [DATA_W-1:0] dout_dram,
   output logic              ready_dram
);

   localparam int WORDS = 1 << DEPTH_LOG2;
   localparam int CNT_W = 9;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [DATA_W-1:0]       din_q;
   logic                    rw_q;
   logic [DATA_W-1:0]       dout_q;
   logic                    ready_q;
   logic [DATA_W-1:0]       mem_q [WORDS];

   logic [CNT_W-1:0]        load_d;
   logic                    done_d;
   logic                    we_d;
   logic                    unused_addr;

   // Only the word-index bits matter; low and high bits alias.
   assign unused_addr = ^{addr_dram[ADDR_W-1:DEPTH_LOG2+2], addr_dram[1:0]};

`ifdef DRAM_RESP_RANDLAT_EN
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   assign lfsr_d = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign load_d = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[2:0]);
`else
   assign load_d = CNT_W'(LATENCY - 1);
`endif

   assign done_d = (state_q == WAIT) && (cnt_q == '0);
   assign we_d   = done_d && rw_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         din_q   <= '0;
         rw_q    <= 1'b0;
         dout_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b0;
               if (valid_dram) begin
                  idx_q   <= addr_dram[DEPTH_LOG2+1:2];
                  din_q   <= din_dram;
                  rw_q    <= rw_dram;
                  cnt_q   <= load_d;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  if (!rw_q) begin
                     dout_q <= mem_q[idx_q];
                  end
                  ready_q <= 1'b1;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Array has no reset; an aborted write never asserts we_d.
   always_ff @(posedge clk) begin
      if (we_d) begin
         mem_q[idx_q] <= din_q;
      end
   end

   assign dout_dram  = dout_q;
   assign ready_dram = ready_q;

endmodule

// File: tb/tb_dram_bram_responder.sv
// Directed bench for dram_bram_responder: LATENCY=4 main instance,
// LATENCY=1 small instance for random scoreboard traffic.
module tb_dram_bram_responder;

   localparam int LAT_A = 4;
   localparam int LAT_B = 1;

   logic        clk;
   logic        rstn;
   logic [26:0] addr_r;
   logic [31:0] din_r;
   logic        rw_r;
   logic        va;
   logic        vb;
   logic [31:0] dout_a;
   logic [31:0] dout_b;
   logic        ready_a;
   logic        ready_b;

   int checks = 0;
   int errors = 0;

   dram_bram_responder #(
      .ADDR_W(27), .DATA_W(32), .DEPTH_LOG2(14), .LATENCY(LAT_A)
   ) u_a (
      .clk(clk), .rstn(rstn), .addr_dram(addr_r), .din_dram(din_r),
      .rw_dram(rw_r), .valid_dram(va), .dout_dram(dout_a),
      .ready_dram(ready_a)
   );

   dram_bram_responder #(
      .ADDR_W(27), .DATA_W(32), .DEPTH_LOG2(6), .LATENCY(LAT_B)
   ) u_b (
      .clk(clk), .rstn(rstn), .addr_dram(addr_r), .din_dram(din_r),
      .rw_dram(rw_r), .valid_dram(vb), .dout_dram(dout_b),
      .ready_dram(ready_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic chk_lat(input string tag, input int lat, input int l);
`ifdef DRAM_RESP_RANDLAT_EN
      chk(tag, 32'((lat >= l) && (lat <= l + 7)), 32'd1);
`else
      chk(tag, 32'(lat), 32'(l));
`endif
   endtask

   function automatic logic rdy(input bit b);
      return b ? ready_b : ready_a;
   endfunction

   function automatic logic [31:0] dout(input bit b);
      return b ? dout_b : dout_a;
   endfunction

   task automatic req(input bit b, input logic rw, input logic [26:0] addr,
                      input logic [31:0] din, input bit chg,
                      input logic [31:0] din2,
                      output logic [31:0] data, output int lat);
      bit got;
      @(negedge clk);
      addr_r = addr;
      din_r  = din;
      rw_r   = rw;
      va     = !b;
      vb     = b;
      @(posedge clk);
      lat = 0;
      got = 0;
      while (!got && lat < 300) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (chg && lat == 1) din_r = din2;
         if (rdy(b)) got = 1;
      end
      if (!got) chk("timeout", 32'd0, 32'd1);
      data = dout(b);
      va   = 1'b0;
      vb   = 1'b0;
      @(negedge clk);
      chk("pulse1", 32'(rdy(b)), 32'd0);
   endtask

   logic [31:0] d;
   int          lat;
   logic [31:0] mdl [64];
   bit          known [64];

   initial begin
      rstn   = 1'b0;
      va     = 1'b0;
      vb     = 1'b0;
      addr_r = '0;
      din_r  = '0;
      rw_r   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready_a), 32'd0);
      chk("rst_dout", dout_a, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      req(0, 1, 27'd0, 32'h0f0f0f0f, 0, 0, d, lat);
      chk_lat("lat_w0", lat, LAT_A);
      req(0, 0, 27'd0, 0, 0, 0, d, lat);
      chk("rd0", d, 32'h0f0f0f0f);
      chk_lat("lat_r0", lat, LAT_A);

      req(0, 1, 27'd4, 32'h1e1e1e1e, 0, 0, d, lat);
      req(0, 0, 27'd4, 0, 0, 0, d, lat);
      chk("rd4", d, 32'h1e1e1e1e);
      req(0, 0, 27'd0, 0, 0, 0, d, lat);
      chk("rd0_again", d, 32'h0f0f0f0f);

      req(0, 0, 27'd6, 0, 0, 0, d, lat);
      chk("rd6_lowbits", d, 32'h1e1e1e1e);
      req(0, 0, 27'd65536, 0, 0, 0, d, lat);
      chk("rd_wrap", d, 32'h0f0f0f0f);

      // din changes mid-request; latched value must be written
      req(0, 1, 27'd12, 32'haaaa5555, 1, 32'h12345678, d, lat);
      chk("dout_hold", d, 32'h0f0f0f0f);
      req(0, 0, 27'd12, 0, 0, 0, d, lat);
      chk("rd12_latched", d, 32'haaaa5555);

      req(0, 1, 27'd8, 32'h11223344, 0, 0, d, lat);
      @(negedge clk);
      addr_r = 27'd8;
      din_r  = 32'hdeadbeef;
      rw_r   = 1'b1;
      va     = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("abort_ready", 32'(ready_a), 32'd0);
      chk("abort_dout", dout_a, 32'd0);
      va = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_nopulse", 32'(ready_a), 32'd0);
      end
      rstn = 1'b1;
      req(0, 0, 27'd8, 0, 0, 0, d, lat);
      chk("rd8_old", d, 32'h11223344);

      req(1, 1, 27'd0, 32'h5a5a0001, 0, 0, d, lat);
      chk_lat("b_lat_w", lat, LAT_B);
      req(1, 0, 27'd0, 0, 0, 0, d, lat);
      chk_lat("b_lat_r", lat, LAT_B);
      chk("b_rd0", d, 32'h5a5a0001);

      for (int i = 0; i < 64; i++) known[i] = 0;
      for (int n = 0; n < 100; n++) begin
         logic [26:0] a;
         logic [31:0] w;
         logic        r;
         int          idx;
         idx = int'($urandom_range(0, 63));
         a   = 27'(idx * 4 + int'($urandom_range(0, 3))
                   + int'($urandom_range(0, 3)) * 256);
         r   = 1'($urandom_range(0, 1));
         w   = $urandom;
         req(1, r, a, w, 0, 0, d, lat);
         chk_lat("b_rand_lat", lat, LAT_B);
         if (r) begin
            mdl[idx]   = w;
            known[idx] = 1;
         end else if (known[idx]) begin
            chk("b_rand_rd", d, mdl[idx]);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
